// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin sharing of the vga_adapter pixel port among rectangle-fill clients
module vga_plot_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   rect_x,
  input  logic [7*NUM_REQ-1:0]   rect_y,
  input  logic [8*NUM_REQ-1:0]   rect_w,
  input  logic [7*NUM_REQ-1:0]   rect_h,
  input  logic [3*NUM_REQ-1:0]   rect_col,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy,
  output logic [7:0]             x,
  output logic [6:0]             y,
  output logic [2:0]             colour,
  output logic                   plot
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [1:0] IDLE = 2'd0, DRAW = 2'd1, DONE = 2'd2;
  logic [1:0]         st;
  logic [IW-1:0]      rr_ptr, win, sel;
  logic [7:0]         x0, w, cx;
  logic [6:0]         y0, h, cy;
  logic [2:0]         col;
  logic [NUM_REQ-1:0] avail;
  logic [7:0]         xs [NUM_REQ];
  logic [7:0]         ws [NUM_REQ];
  logic [6:0]         ys [NUM_REQ];
  logic [6:0]         hs [NUM_REQ];
  logic [2:0]         cs [NUM_REQ];
  logic [8:0]         sx;
  logic [7:0]         sy;
  logic               row_end, last;
  // a client whose done pulse is showing still holds req this cycle, so it is not re-granted
  assign avail   = req & ~done;
  assign busy    = st != IDLE;
  assign grant   = busy ? NUM_REQ'(1) << win : '0;
  assign sx      = {1'b0, x0} + {1'b0, cx};
  assign sy      = {1'b0, y0} + {1'b0, cy};
  assign row_end = cx == w - 8'd1;
  assign last    = row_end && cy == h - 7'd1;
  // split the packed client fields into per-client arrays
  always_comb
    for (int i = 0; i < NUM_REQ; i++) begin
      xs[i] = rect_x[8*i +: 8];
      ys[i] = rect_y[7*i +: 7];
      ws[i] = rect_w[8*i +: 8];
      hs[i] = rect_h[7*i +: 7];
      cs[i] = rect_col[3*i +: 3];
    end
  // first available requester at or after rr_ptr, wrapping at NUM_REQ
  always_comb begin
    sel = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (avail[IW'((int'(rr_ptr) + k) % NUM_REQ)]) sel = IW'((int'(rr_ptr) + k) % NUM_REQ);
  end
  // grant, scan one pixel per enabled cycle with clipping, then pulse done and advance the pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      st     <= IDLE;
      rr_ptr <= '0;
      win    <= '0;
      x0     <= '0;
      y0     <= '0;
      w      <= '0;
      h      <= '0;
      col    <= '0;
      cx     <= '0;
      cy     <= '0;
      done   <= '0;
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
    end else begin
      done <= '0;
      plot <= 1'b0;
      if (st == IDLE && |avail) begin
        win <= sel;
        x0  <= xs[sel];
        y0  <= ys[sel];
        w   <= ws[sel];
        h   <= hs[sel];
        col <= cs[sel];
        cx  <= '0;
        cy  <= '0;
        st  <= (ws[sel] == 8'd0 || hs[sel] == 7'd0) ? DONE : DRAW;
      end
      if (st == DRAW && enable) begin
        x      <= sx[7:0];
        y      <= sy[6:0];
        colour <= col;
        plot   <= sx < 9'(SCREEN_W) && sy < 8'(SCREEN_H);
        cx     <= row_end ? 8'd0 : cx + 8'd1;
        cy     <= row_end ? cy + 7'd1 : cy;
        if (last) st <= DONE;
      end
      if (st == DONE) begin
        done   <= NUM_REQ'(1) << win;
        rr_ptr <= win == IW'(NUM_REQ - 1) ? '0 : win + 1'b1;
        st     <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb_vga_plot_arbiter: directed and randomized checks of the plot arbiter against a rectangle-list model
module tb_vga_plot_arbiter;
  logic        clk = 1'b0, reset = 1'b1, en_off = 1'b0, rand_en = 1'b0, en_rnd = 1'b1;
  logic        enable;
  logic [2:0]  req = '0;
  logic [23:0] rect_x = '0, rect_w = '0;
  logic [20:0] rect_y = '0, rect_h = '0;
  logic [8:0]  rect_col = '0;
  logic [2:0]  grant, done;
  logic        busy, plot;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  int          tests = 0, fails = 0, cyc = 0, first_pc = 0, last_pc = 0, done_cyc = 0, mptr = 0;
  int          mx [3], my [3], mw [3], mh [3], mc [3];
  logic [17:0] pq [$];

  vga_plot_arbiter dut (
    .clock(clk), .reset(reset), .enable(enable), .req(req),
    .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h), .rect_col(rect_col),
    .grant(grant), .done(done), .busy(busy), .x(x), .y(y), .colour(colour), .plot(plot)
  );

  initial forever #5 clk = ~clk;
  assign enable = en_off ? 1'b0 : (rand_en ? en_rnd : 1'b1);
  always @(negedge clk) en_rnd <= ($urandom_range(0, 3) != 0);
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (plot) begin
      if (pq.size() == 0) first_pc <= cyc;
      last_pc <= cyc;
      pq.push_back({x, y, colour});
    end
    if (|done) done_cyc <= cyc;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rect(input int c, input int rx, input int ry, input int rw, input int rh, input int rc);
    mx[c] = rx; my[c] = ry; mw[c] = rw; mh[c] = rh; mc[c] = rc;
    rect_x[8*c +: 8]   = 8'(rx);
    rect_y[7*c +: 7]   = 7'(ry);
    rect_w[8*c +: 8]   = 8'(rw);
    rect_h[7*c +: 7]   = 7'(rh);
    rect_col[3*c +: 3] = 3'(rc);
  endtask

  function automatic int pick(input logic [2:0] s, input int p);
    for (int k = 0; k < 3; k++)
      if (s[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    mptr = 0;
    pq.delete();
  endtask

  // wait for client c's done pulse, compare its visible pixel list with the clipped rectangle, drop req bits in drop
  task automatic serve(input int c, input logic [2:0] drop);
    logic [17:0] eq [$];
    logic [2:0]  dv = '0;
    int          sxm, sym, n;
    for (int j = 0; j < mh[c]; j++)
      for (int i = 0; i < mw[c]; i++) begin
        sxm = mx[c] + i;
        sym = my[c] + j;
        if (sxm < 160 && sym < 120) eq.push_back({8'(sxm), 7'(sym), 3'(mc[c])});
      end
    for (int i = 0; i < 600 && dv == 3'b000; i++) begin
      tick();
      dv = done;
    end
    check("done_seen", 32'(|dv), 1);
    check("done_vec", 32'(dv), 32'(1 << c));
    check("npix", pq.size(), eq.size());
    n = pq.size() < eq.size() ? pq.size() : eq.size();
    for (int i = 0; i < n; i++) check($sformatf("pix%0d_client%0d", i, c), 32'(pq[i]), 32'(eq[i]));
    pq.delete();
    req = req & ~drop;
    mptr = (c + 1) % 3;
    tick();
    check("done_width", 32'(done), 0);
  endtask

  initial begin
    int rcyc, dsave, c;
    logic [2:0] act;
    repeat (3) tick();
    check("rst_out", {grant, done, busy, x, y, colour, plot}, 0);
    reset = 1'b0;
    tick();
    // single 3x2 rectangle
    set_rect(0, 10, 20, 3, 2, 4);
    req = 3'b001;
    rcyc = cyc;
    tick();
    check("t1_grant", 32'(grant), 1);
    check("t1_busy", 32'(busy), 1);
    serve(0, 3'b001);
    check("t1_first_lat", first_pc - rcyc, 2);
    check("t1_done_lat", done_cyc - last_pc, 1);
    // round-robin with all requests held
    do_reset();
    set_rect(0, 1, 1, 1, 1, 1);
    set_rect(1, 2, 2, 1, 1, 2);
    set_rect(2, 3, 3, 1, 1, 3);
    req = 3'b111;
    serve(0, 3'b000);
    serve(1, 3'b000);
    serve(2, 3'b000);
    serve(0, 3'b111);
    tick();
    check("t2_idle", 32'(busy), 0);
    req = 3'b010;
    serve(1, 3'b010);
    // clipping at the bottom-right corner
    set_rect(0, 158, 118, 4, 4, 7);
    req = 3'b001;
    rcyc = cyc;
    serve(0, 3'b001);
    check("t3_scan_len", done_cyc - rcyc, 18);
    // zero-size rectangle
    set_rect(1, 30, 30, 0, 5, 6);
    req = 3'b010;
    rcyc = cyc;
    serve(1, 3'b010);
    check("t4_done_lat", done_cyc - rcyc, 2);
    // stall mid-scan
    set_rect(2, 40, 50, 4, 1, 5);
    req = 3'b100;
    repeat (3) tick();
    check("t5_pre_stall", pq.size(), 2);
    en_off = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_stall_plot", 32'(plot), 0);
    end
    en_off = 1'b0;
    serve(2, 3'b100);
    // reset in the middle of a 10x10 scan
    set_rect(0, 5, 5, 1, 1, 1);
    req = 3'b001;
    serve(0, 3'b001);
    set_rect(1, 20, 20, 10, 10, 2);
    req = 3'b010;
    repeat (20) tick();
    check("t6_busy_before", 32'(busy), 1);
    reset = 1'b1;
    tick();
    check("t6_rst_plot", 32'(plot), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_grant", 32'(grant), 0);
    check("t6_rst_done", 32'(done), 0);
    req = 3'b000;
    dsave = done_cyc;
    tick();
    reset = 1'b0;
    mptr = 0;
    pq.delete();
    repeat (5) tick();
    check("t6_no_done", done_cyc, dsave);
    set_rect(0, 1, 1, 1, 1, 1);
    set_rect(1, 2, 2, 1, 1, 2);
    set_rect(2, 3, 3, 1, 1, 3);
    req = 3'b111;
    serve(0, 3'b001);
    serve(1, 3'b010);
    serve(2, 3'b100);
    // randomized request sets, rectangles and enable gaps
    rand_en = 1'b1;
    for (int r = 0; r < 25; r++) begin
      act = 3'($urandom_range(1, 7));
      for (int k = 0; k < 3; k++)
        if (act[k]) set_rect(k, $urandom_range(0, 170), $urandom_range(0, 127), $urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 7));
      req = act;
      while (act != 3'b000) begin
        c = pick(act, mptr);
        serve(c, 3'(1 << c));
        act = act & ~3'(1 << c);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_en = 1'b0;
    tick();
    check("end_idle", {grant, done, busy, plot}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
